// File: rtl/rc4_pkg.sv
// Shared RC4 definitions used by the key-scheduling and pseudo-random generation machines.
//   S_DEPTH       : number of entries in the S permutation memory
//   rc4_byte_t    : 8-bit data type used throughout the RC4 datapaths
//   prga_state_t  : state encoding of the PRGA decrypt machine
//   is_plain_char : true for bytes accepted as plaintext (space or lower-case letter)
package rc4_pkg;

   localparam int unsigned S_DEPTH = 256;

   typedef logic [7:0] rc4_byte_t;

   typedef enum logic [3:0] {
      StIdle,
      StRdI,
      StWtI,
      StRdJ,
      StWtJ,
      StWrI,
      StWrJ,
      StRdF,
      StWtF,
      StWrOut,
      StDone
   } prga_state_t;

   function automatic logic is_plain_char(rc4_byte_t b);
      return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7a));
   endfunction

endpackage

// File: rtl/prga_decrypt_fsm.sv
// RC4 pseudo-random generation stage. Runs after key scheduling: generates the keystream from
// the S memory, XORs it with the encrypted-message ROM and writes plaintext to the RAM.
// Nine cycles per byte; done is sticky until reset_n.
//
// Optional feature (macro PRGA_VALID_CHECK_EN): a plaintext byte that is neither space nor
// 'a'..'z' is not written; the machine stops with done=1 and key_fail=1 (sticky).
// Without the macro key_fail is tied low and every byte is written.
//
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   start        level; key scheduling complete, begin decryption
//   s_q          S memory read data (1-cycle latency)
//   s_address    S memory address
//   s_data       S memory write data
//   s_wren       S memory write enable
//   rom_address  encrypted-message ROM address
//   rom_q        encrypted byte (1-cycle latency)
//   ram_address  decrypted-message RAM address
//   ram_data     plaintext byte
//   ram_wren     RAM write enable
//   done         decryption finished (sticky)
//   key_fail     plaintext check failed (sticky)
module prga_decrypt_fsm
   import rc4_pkg::*;
#(
   parameter int unsigned MSG_LEN = 32,
   parameter int unsigned MSG_AW  = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [7:0]        s_q,
   output logic [7:0]        s_address,
   output logic [7:0]        s_data,
   output logic              s_wren,
   output logic [MSG_AW-1:0] rom_address,
   input  logic [7:0]        rom_q,
   output logic [MSG_AW-1:0] ram_address,
   output logic [7:0]        ram_data,
   output logic              ram_wren,
   output logic              done,
   output logic              key_fail
);

   localparam logic [MSG_AW-1:0] KLast = MSG_AW'(MSG_LEN - 1);

   prga_state_t state_q, state_d;
   rc4_byte_t   i_q, i_d;
   rc4_byte_t   j_q, j_d;
   rc4_byte_t   si_q, si_d;
   rc4_byte_t   sj_q, sj_d;
   rc4_byte_t   f_q, f_d;
   rc4_byte_t   enc_q, enc_d;
   logic [MSG_AW-1:0] k_q, k_d;
   rc4_byte_t   plain;

   assign plain = f_q ^ enc_q;

`ifdef PRGA_VALID_CHECK_EN
   logic key_fail_q, key_fail_d;
   assign key_fail = key_fail_q;
`else
   assign key_fail = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StIdle;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         si_q    <= '0;
         sj_q    <= '0;
         f_q     <= '0;
         enc_q   <= '0;
`ifdef PRGA_VALID_CHECK_EN
         key_fail_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         f_q     <= f_d;
         enc_q   <= enc_d;
`ifdef PRGA_VALID_CHECK_EN
         key_fail_q <= key_fail_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      j_d         = j_q;
      k_d         = k_q;
      si_d        = si_q;
      sj_d        = sj_q;
      f_d         = f_q;
      enc_d       = enc_q;
`ifdef PRGA_VALID_CHECK_EN
      key_fail_d  = key_fail_q;
`endif
      s_address   = '0;
      s_data      = '0;
      s_wren      = 1'b0;
      rom_address = '0;
      ram_address = '0;
      ram_data    = '0;
      ram_wren    = 1'b0;
      done        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               state_d = StRdI;
            end
         end
         StRdI: begin
            s_address = i_q + 8'd1;
            i_d       = i_q + 8'd1;
            state_d   = StWtI;
         end
         StWtI: begin
            // s_q holds S[i] for the already-incremented i
            s_address = i_q;
            si_d      = s_q;
            j_d       = j_q + s_q;
            state_d   = StRdJ;
         end
         StRdJ: begin
            s_address = j_q;
            state_d   = StWtJ;
         end
         StWtJ: begin
            sj_d    = s_q;
            state_d = StWrI;
         end
         StWrI: begin
            s_address = i_q;
            s_data    = sj_q;
            s_wren    = 1'b1;
            state_d   = StWrJ;
         end
         StWrJ: begin
            s_address = j_q;
            s_data    = si_q;
            s_wren    = 1'b1;
            state_d   = StRdF;
         end
         StRdF: begin
            // Sum of pre-swap values equals sum of post-swap values
            s_address   = si_q + sj_q;
            rom_address = k_q;
            state_d     = StWtF;
         end
         StWtF: begin
            f_d     = s_q;
            enc_d   = rom_q;
            state_d = StWrOut;
         end
         StWrOut: begin
            ram_address = k_q;
            ram_data    = plain;
            ram_wren    = 1'b1;
            if (k_q == KLast) begin
               state_d = StDone;
            end else begin
               k_d     = k_q + MSG_AW'(1);
               state_d = StRdI;
            end
`ifdef PRGA_VALID_CHECK_EN
            if (!is_plain_char(plain)) begin
               ram_wren   = 1'b0;
               key_fail_d = 1'b1;
               k_d        = k_q;
               state_d    = StDone;
            end
`endif
         end
         StDone: begin
            done = 1'b1;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_prga_decrypt_fsm.sv
module tb_prga_decrypt_fsm;

   localparam int L  = 32;
   localparam int AW = 5;

   localparam int KA = 0;  // s_address
   localparam int KW = 1;  // {s_wren, s_address, s_data}
   localparam int KO = 2;  // {ram_wren, ram_address, ram_data}
   localparam int KS = 3;  // S memory contents
   localparam int KR = 4;  // RAM contents

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [7:0]    s_q;
   logic [7:0]    s_address;
   logic [7:0]    s_data;
   logic          s_wren;
   logic [AW-1:0] rom_address;
   logic [7:0]    rom_q;
   logic [AW-1:0] ram_address;
   logic [7:0]    ram_data;
   logic          ram_wren;
   logic          done;
   logic          key_fail;

   always #5 clk = ~clk;

   prga_decrypt_fsm #(
      .MSG_LEN(L),
      .MSG_AW (AW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .s_q        (s_q),
      .s_address  (s_address),
      .s_data     (s_data),
      .s_wren     (s_wren),
      .rom_address(rom_address),
      .rom_q      (rom_q),
      .ram_address(ram_address),
      .ram_data   (ram_data),
      .ram_wren   (ram_wren),
      .done       (done),
      .key_fail   (key_fail)
   );

   // Memory models, 1-cycle read latency; load copies s_init and clears RAM and counters.
   logic [7:0] s_mem [256];
   logic [7:0] s_init[256];
   logic [7:0] rom   [32];
   logic [7:0] ram   [32];
   logic       load = 1'b0;
   int         s_wr_cnt;
   int         ram_wr_cnt;

   always @(posedge clk) begin
      if (load) begin
         for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
         for (int x = 0; x < 32; x++) ram[x] <= 8'h00;
         s_wr_cnt   <= 0;
         ram_wr_cnt <= 0;
      end else begin
         s_q   <= s_mem[s_address];
         rom_q <= rom[rom_address];
         if (s_wren) begin
            s_mem[s_address] <= s_data;
            s_wr_cnt <= s_wr_cnt + 1;
         end
         if (ram_wren) begin
            ram[ram_address] <= ram_data;
            ram_wr_cnt <= ram_wr_cnt + 1;
         end
      end
   end

   int tests = 0;
   int fails = 0;
   int ecount = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      ecount++;
   endtask

   task automatic step_to(input int n);
      while (ecount < n) step();
   endtask

   function automatic logic [63:0] all_outs();
      return {26'd0, s_address, s_data, s_wren, rom_address, ram_address, ram_data, ram_wren,
              done, key_fail};
   endfunction

   // Reference model: straightforward RC4 PRGA on plain arrays.
   int m_s[256];
   int m_ram[32];
   int m_nbytes, m_nwr;
   bit m_kf;

   task automatic run_model();
      int i, j, t, f, p;
      for (int x = 0; x < 256; x++) m_s[x] = int'(s_init[x]);
      for (int x = 0; x < 32; x++) m_ram[x] = 0;
      i = 0; j = 0; m_nbytes = 0; m_nwr = 0; m_kf = 0;
      for (int k = 0; k < L; k++) begin
         i = (i + 1) % 256;
         j = (j + m_s[i]) % 256;
         t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
         f = m_s[(m_s[i] + m_s[j]) % 256];
         p = f ^ int'(rom[k]);
         m_nbytes++;
`ifdef PRGA_VALID_CHECK_EN
         if (!(p == 32 || (p >= 97 && p <= 122))) begin
            m_kf = 1;
            break;
         end
`endif
         m_ram[k] = p;
         m_nwr++;
      end
   endtask

   task automatic set_identity();
      for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
   endtask

   task automatic set_random_rom();
      for (int x = 0; x < 32; x++) rom[x] = 8'($urandom);
   endtask

   // Resets the DUT, loads memories, then the next edge samples start in IDLE (ecount 0).
   task automatic begin_run();
      reset_n = 1'b0;
      start   = 1'b0;
      load    = 1'b1;
      @(posedge clk); #1;
      load    = 1'b0;
      @(posedge clk); #1;
      run_model();
      reset_n = 1'b1;
      start   = 1'b1;
      @(posedge clk); #1;
      ecount  = 0;
   endtask

   task automatic finish_run(input string name);
      int bad_s, bad_r;
      while (!done && ecount < 9 * L + 20) step();
      // done rises 9*n edges after the start edge (edge 9*n+1 counting the start edge as 1)
      chk({name, "_done_edge"}, 64'(ecount), 64'(9 * m_nbytes));
      bad_s = 0;
      bad_r = 0;
      for (int x = 0; x < 256; x++) if (int'(s_mem[x]) != m_s[x]) bad_s++;
      for (int x = 0; x < 32; x++) if (int'(ram[x]) != m_ram[x]) bad_r++;
      chk({name, "_s_mismatches"}, 64'(bad_s), 64'd0);
      chk({name, "_ram_mismatches"}, 64'(bad_r), 64'd0);
      chk({name, "_s_wren_count"}, 64'(s_wr_cnt), 64'(2 * m_nbytes));
      chk({name, "_ram_wren_count"}, 64'(ram_wr_cnt), 64'(m_nwr));
      chk({name, "_key_fail"}, 64'(key_fail), 64'(m_kf));
   endtask

   typedef struct {
      string       name;
      int          edge_n;
      int          kind;
      int          addr;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[13];

   initial begin
      forever begin
         #3000000;
         $display("FAIL watchdog: simulation time limit reached");
         $fatal(1, "timeout");
      end
   end

   initial begin
      int wr_s, wr_r, j, t;
      logic [63:0] act;

      // Identity S with ROM[0]=0x63, ROM[1]=0x60: byte0 i=j=1, f=2 -> 0x61; byte1 f=5 -> 0x65.
      tbl[0]  = '{"b0_rd_i_addr", 0,  KA, 0, 32'h00001};
      tbl[1]  = '{"b0_wr_i",      4,  KW, 0, 32'h10101};
      tbl[2]  = '{"b0_wr_j",      5,  KW, 0, 32'h10101};
      tbl[3]  = '{"b0_s1_kept",   5,  KS, 1, 32'h00001};
      tbl[4]  = '{"b0_rd_f_addr", 6,  KA, 0, 32'h00002};
      tbl[5]  = '{"b0_wr_out",    8,  KO, 0, 32'h10061};
      tbl[6]  = '{"ram0",         9,  KR, 0, 32'h00061};
      tbl[7]  = '{"b1_wr_i",      13, KW, 0, 32'h10203};
      tbl[8]  = '{"b1_wr_j",      14, KW, 0, 32'h10302};
      tbl[9]  = '{"b1_rd_f_addr", 15, KA, 0, 32'h00005};
      tbl[10] = '{"ram1",         18, KR, 1, 32'h00065};
      tbl[11] = '{"s2_swapped",   18, KS, 2, 32'h00003};
      tbl[12] = '{"s3_swapped",   18, KS, 3, 32'h00002};

      reset_n = 1'b0;
      start   = 1'b1;
      set_identity();
      set_random_rom();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", all_outs(), 64'd0);

      // Test-plan run on identity S
      set_identity();
      set_random_rom();
      rom[0] = 8'h63;
      rom[1] = 8'h60;
      begin_run();
      for (int v = 0; v < 13; v++) begin
         step_to(tbl[v].edge_n);
         case (tbl[v].kind)
            KA:      act = 64'(s_address);
            KW:      act = 64'({s_wren, s_address, s_data});
            KO:      act = 64'({ram_wren, 3'b000, ram_address, ram_data});
            KS:      act = 64'(s_mem[tbl[v].addr]);
            default: act = 64'(ram[tbl[v].addr]);
         endcase
         chk(tbl[v].name, act, 64'(tbl[v].exp));
      end
      finish_run("identity");

      // start held high after DONE: no further writes, done stays high
      wr_s = s_wr_cnt;
      wr_r = ram_wr_cnt;
      repeat (20) step();
      chk("post_done_s_writes", 64'(s_wr_cnt), 64'(wr_s));
      chk("post_done_ram_writes", 64'(ram_wr_cnt), 64'(wr_r));
      chk("post_done_done", 64'(done), 64'd1);

      // KSA with 24-bit key 0x000249, then full decrypt
      set_identity();
      j = 0;
      for (int x = 0; x < 256; x++) begin
         int kb;
         kb = (x % 3 == 0) ? 8'h00 : ((x % 3 == 1) ? 8'h02 : 8'h49);
         j = (j + int'(s_init[x]) + kb) % 256;
         t = int'(s_init[x]);
         s_init[x] = s_init[j];
         s_init[j] = 8'(t);
      end
      set_random_rom();
      begin_run();
      finish_run("ksa_key");

      // Reset during WR_J of byte 5, then restart from scratch
      set_identity();
      set_random_rom();
      begin_run();
      if (m_nbytes >= 6) begin
         step_to(50);
         chk("b5_wr_j_wren", 64'(s_wren), 64'd1);
         reset_n = 1'b0;
         step();
         chk("abort_outputs", all_outs(), 64'd0);
         chk("abort_ram_writes", 64'(ram_wr_cnt), 64'd5);
      end
      begin_run();
      chk("restart_rd_i_addr", 64'(s_address), 64'd1);
      finish_run("restart");

      // Plaintext 0x41 on byte 0 (identity S gives f=2)
      set_identity();
      set_random_rom();
      rom[0] = 8'h43;
      begin_run();
      step_to(8);
`ifdef PRGA_VALID_CHECK_EN
      chk("bad_char_wren", 64'(ram_wren), 64'd0);
      step();
      chk("bad_char_done", 64'({done, key_fail}), 64'b11);
`else
      chk("bad_char_wren", 64'(ram_wren), 64'd1);
      step();
      chk("bad_char_ram0", 64'(ram[0]), 64'h41);
      chk("bad_char_key_fail", 64'(key_fail), 64'd0);
`endif
      finish_run("bad_char");

      // Random permutations and ciphertext
      for (int r = 0; r < 4; r++) begin
         set_identity();
         for (int x = 255; x > 0; x--) begin
            int y;
            logic [7:0] tmp;
            y = int'($urandom_range(x, 0));
            tmp = s_init[x];
            s_init[x] = s_init[y];
            s_init[y] = tmp;
         end
         set_random_rom();
         begin_run();
         finish_run($sformatf("random%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
